// File: rtl/paint_brush_ctrl_if.sv
`default_nettype none
// ==== paint_brush_ctrl_if : frame-memory write port (address, data, req/ack) ====
// ==== Rev 1.0                                                                ====
interface paint_brush_ctrl_if #(
  parameter int COORD_W = 8,
  parameter int COLOR_W = 8
);
  logic [COORD_W-1:0] out_x;
  logic [COORD_W-1:0] out_y;
  logic [COLOR_W-1:0] px_data;
  logic               wr_req;
  logic               wr_ack;

  modport master (output out_x, out_y, px_data, wr_req, input wr_ack);
  modport slave  (input out_x, out_y, px_data, wr_req, output wr_ack);
endinterface
`default_nettype wire

// File: rtl/paint_brush_ctrl.sv
`default_nettype none
// ==== paint_brush_ctrl : cursor/palette sequencer that stamps a square brush ====
// ==== Rev 1.0                                                                 ====
module paint_brush_ctrl #(
  parameter int COORD_W   = 8,
  parameter int COLOR_W   = 8,
  parameter int SCREEN_W  = 64,
  parameter int SCREEN_H  = 64,
  parameter int MAX_BRUSH = 4
) (
  input  wire logic               clk,
  input  wire logic               rst,
  input  wire logic               init,
  input  wire logic [COORD_W-1:0] in_x,
  input  wire logic [COORD_W-1:0] in_y,
  input  wire logic               w_C,
  input  wire logic               w_Enter,
  input  wire logic               w_Erase,
  input  wire logic               w_Enter_Paleta,
  input  wire logic               brush_inc,
  input  wire logic               brush_dec,
  input  wire logic               cursor_done,
  input  wire logic               cursor_paleta_done,
  paint_brush_ctrl_if.master      wr,
  output logic                    Cursor_S,
  output logic                    Cursor_Paleta_S,
  output logic                    paleta,
  output logic [3:0]              brush_size,
  output logic                    busy
);

  localparam int          HALF_C = COLOR_W / 2;
  localparam logic [3:0]  MAX_BS = 4'(MAX_BRUSH);

  typedef enum logic [2:0] {
    S_IDLE, S_LATCH, S_DECIDE, S_STAMP,
    S_DRAW_CURSOR, S_PAL_CURSOR, S_PAL_CHECK, S_CHANGE_COLOR
  } state_t;

  state_t             state_q, state_d;
  logic [COORD_W-1:0] base_x_q, base_x_d;
  logic [COORD_W-1:0] base_y_q, base_y_d;
  logic [3:0]         dx_q, dx_d;
  logic [3:0]         dy_q, dy_d;
  logic [3:0]         brush_q, brush_d;
  logic [COLOR_W-1:0] colour_q, colour_d;
  logic [COLOR_W-1:0] data_q, data_d;

  // One extra bit so pixels past the right/bottom edge clip instead of wrapping.
  logic [COORD_W:0] sum_x, sum_y;
  logic             in_bounds, last_dx, last_dy;

  assign sum_x     = {1'b0, base_x_q} + (COORD_W+1)'(dx_q);
  assign sum_y     = {1'b0, base_y_q} + (COORD_W+1)'(dy_q);
  assign in_bounds = (sum_x < (COORD_W+1)'(SCREEN_W)) && (sum_y < (COORD_W+1)'(SCREEN_H));
  assign last_dx   = (dx_q == brush_q - 4'd1);
  assign last_dy   = (dy_q == brush_q - 4'd1);

  assign wr.out_x   = sum_x[COORD_W-1:0];
  assign wr.out_y   = sum_y[COORD_W-1:0];
  assign wr.px_data = data_q;
  assign wr.wr_req  = (state_q == S_STAMP) && in_bounds;

  assign Cursor_S        = (state_q == S_DRAW_CURSOR);
  assign Cursor_Paleta_S = (state_q == S_PAL_CURSOR);
  assign paleta          = (state_q == S_PAL_CURSOR);
  assign busy            = (state_q != S_IDLE);
  assign brush_size      = brush_q;

  always_comb begin
    state_d  = state_q;
    base_x_d = base_x_q;
    base_y_d = base_y_q;
    dx_d     = dx_q;
    dy_d     = dy_q;
    brush_d  = brush_q;
    colour_d = colour_q;
    data_d   = data_q;
    case (state_q)
      S_IDLE: if (init) state_d = S_LATCH;
      S_LATCH: begin
        base_x_d = in_x;
        base_y_d = in_y;
        state_d  = S_DECIDE;
      end
      S_DECIDE: begin
        dx_d = 4'd0;
        dy_d = 4'd0;
        if (w_C) begin
          state_d = S_PAL_CURSOR;
        end else if (w_Enter) begin
          state_d = S_STAMP;
          data_d  = colour_q;
        end else if (w_Erase) begin
          state_d = S_STAMP;
          data_d  = '0;
        end else begin
          state_d = S_DRAW_CURSOR;
          if (brush_inc && !brush_dec && brush_q < MAX_BS)
            brush_d = brush_q + 4'd1;
          else if (brush_dec && !brush_inc && brush_q > 4'd1)
            brush_d = brush_q - 4'd1;
        end
      end
      S_STAMP: begin
        // Out-of-screen pixels advance without a handshake.
        if (!in_bounds || wr.wr_ack) begin
          if (last_dx) begin
            dx_d = 4'd0;
            if (last_dy) begin
              dy_d    = 4'd0;
              state_d = S_LATCH;
            end else begin
              dy_d = dy_q + 4'd1;
            end
          end else begin
            dx_d = dx_q + 4'd1;
          end
        end
      end
      S_DRAW_CURSOR: if (cursor_done) state_d = S_LATCH;
      S_PAL_CURSOR:  if (cursor_paleta_done) state_d = S_PAL_CHECK;
      S_PAL_CHECK:   state_d = w_Enter_Paleta ? S_CHANGE_COLOR : S_PAL_CURSOR;
      S_CHANGE_COLOR: begin
        colour_d = {in_x[HALF_C-1:0], in_y[HALF_C-1:0]};
        state_d  = S_LATCH;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(negedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      base_x_q <= '0;
      base_y_q <= '0;
      dx_q     <= 4'd0;
      dy_q     <= 4'd0;
      brush_q  <= 4'd1;
      colour_q <= '0;
      data_q   <= '0;
    end else begin
      state_q  <= state_d;
      base_x_q <= base_x_d;
      base_y_q <= base_y_d;
      dx_q     <= dx_d;
      dy_q     <= dy_d;
      brush_q  <= brush_d;
      colour_q <= colour_d;
      data_q   <= data_d;
    end
  end

endmodule
`default_nettype wire
